// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM for the bubble-sort processor: fetch handshake, decode to ALU op,
// and sequencing of execute, memory and write-back steps with sticky illegal/timeout flags.
module ctrl_fsm #(
    parameter int unsigned IMEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        fetch_ack,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic        fetch_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  alu_control,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        reg_dst_rd,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout
);

    localparam logic [3:0] WAIT_MAX = 4'(IMEM_WAIT_MAX);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE   = 3'd0,
        C_ADDI    = 3'd1,
        C_LW      = 3'd2,
        C_SW      = 3'd3,
        C_BRANCH  = 3'd4,
        C_JUMP    = 3'd5,
        C_ILLEGAL = 3'd6
    } cls_t;

    function automatic cls_t classify(input logic [31:0] ir);
        cls_t c;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A: c = C_RTYPE;
                    default:                                         c = C_ILLEGAL;
                endcase
            end
            6'h08:                                     c = C_ADDI;
            6'h23:                                     c = C_LW;
            6'h2B:                                     c = C_SW;
            6'h04, 6'h05, 6'h07, 6'h01, 6'h06, 6'h09:  c = C_BRANCH;
            6'h02:                                     c = C_JUMP;
            default:                                   c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] alu_op(input logic [31:0] ir);
        logic [3:0] a;
        case (ir[31:26])
            6'h00: begin
                case (ir[5:0])
                    6'h20:   a = 4'd0;
                    6'h22:   a = 4'd1;
                    6'h24:   a = 4'd2;
                    6'h25:   a = 4'd3;
                    6'h00:   a = 4'd4;
                    6'h02:   a = 4'd5;
                    6'h2A:   a = 4'd6;
                    default: a = 4'd0;
                endcase
            end
            6'h04:   a = 4'd7;
            6'h05:   a = 4'd8;
            6'h07:   a = 4'd9;
            6'h01:   a = 4'd10;
            6'h06:   a = 4'd11;
            6'h09:   a = 4'd12;
            default: a = 4'd0;
        endcase
        return a;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    cls_t        cls_s;
    logic        unused_ir_s;

    assign cls_s       = classify(ir_q);
    assign unused_ir_s = ^ir_q[25:6];
    assign state       = state_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;

    // State, instruction and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic and output decode
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        fetch_req   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_control = 4'd0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        reg_dst_rd  = 1'b0;
        mem_to_reg  = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        case (state_q)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    ir_d     = instr;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_q == WAIT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                case (cls_s)
                    C_ILLEGAL: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                    C_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_control = alu_op(ir_q);
                alu_src_imm = (cls_s == C_ADDI) || (cls_s == C_LW) || (cls_s == C_SW);
                case (cls_s)
                    C_BRANCH: begin
                        // ALU result of 1 (zero flag clear) means the condition holds
                        pc_write = ~alu_zero;
                        pc_src   = alu_zero ? 2'd0 : 2'd1;
                        state_d  = S_FETCH;
                    end
                    C_LW, C_SW:      state_d = S_MEM;
                    C_RTYPE, C_ADDI: state_d = S_WB;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_s == C_SW);
                if (dmem_ack) begin
                    state_d = (cls_s == C_LW) ? S_WB : S_FETCH;
                end else if (cnt_q == WAIT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst_rd = (cls_s == C_RTYPE);
                mem_to_reg = (cls_s == C_LW);
                state_d    = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_d;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomized bench for ctrl_fsm: each instruction is expanded into its expected per-cycle
// output trace from the cycle-count rules, then replayed against the DUT.
module tb_ctrl_fsm;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        fetch_ack, dmem_ack, alu_zero;
    logic        fetch_req, dmem_req, dmem_we, alu_src_imm, reg_write;
    logic        reg_dst_rd, mem_to_reg, pc_write, illegal, timeout;
    logic [3:0]  alu_control;
    logic [1:0]  pc_src;
    logic [2:0]  state;

    always #5 clk = ~clk;

    ctrl_fsm #(.IMEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .fetch_ack(fetch_ack),
        .dmem_ack(dmem_ack), .alu_zero(alu_zero), .fetch_req(fetch_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_control(alu_control),
        .alu_src_imm(alu_src_imm), .reg_write(reg_write), .reg_dst_rd(reg_dst_rd),
        .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
        .state(state), .illegal(illegal), .timeout(timeout)
    );

    // Output vector layout: [18:16] state, [15] fetch_req, [14] dmem_req, [13] dmem_we,
    // [12:9] alu_control, [8] alu_src_imm, [7] reg_write, [6] reg_dst_rd, [5] mem_to_reg,
    // [4] pc_write, [3:2] pc_src, [1] illegal, [0] timeout
    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        fa, da, az;
        logic [18:0] exp;
    } cyc_t;

    cyc_t        plan[$];
    logic [18:0] olog[$];
    cyc_t        cur;
    bit          cur_valid = 1'b0;
    bit          ill_m = 1'b0, to_m = 1'b0;
    int          n_vec = 0, n_err = 0;

    function automatic logic [18:0] mk(input logic [2:0] st, input logic fr, dr, dw,
                                       input logic [3:0] alu, input logic imm, rw, rdd, m2r,
                                       input logic pcw, input logic [1:0] pcs);
        return {st, fr, dr, dw, alu, imm, rw, rdd, m2r, pcw, pcs, ill_m, to_m};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // cls: 0 R-type, 1 addi, 2 lw, 3 sw, 4 branch, 5 jump, 6 illegal
    function automatic void dec(input logic [31:0] w, output int cls, output logic [3:0] alu);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        cls = 6;
        alu = 4'd0;
        if (op == 6'h00) begin
            cls = 0;
            case (fn)
                6'h20: alu = 4'd0;
                6'h22: alu = 4'd1;
                6'h24: alu = 4'd2;
                6'h25: alu = 4'd3;
                6'h00: alu = 4'd4;
                6'h02: alu = 4'd5;
                6'h2A: alu = 4'd6;
                default: cls = 6;
            endcase
        end else begin
            case (op)
                6'h08: cls = 1;
                6'h23: cls = 2;
                6'h2B: cls = 3;
                6'h04: begin cls = 4; alu = 4'd7;  end
                6'h05: begin cls = 4; alu = 4'd8;  end
                6'h07: begin cls = 4; alu = 4'd9;  end
                6'h01: begin cls = 4; alu = 4'd10; end
                6'h06: begin cls = 4; alu = 4'd11; end
                6'h09: begin cls = 4; alu = 4'd12; end
                6'h02: cls = 5;
                default: cls = 6;
            endcase
        end
    endfunction

    task automatic push(input logic [31:0] ins, input logic fa, da, az, input logic [18:0] e);
        plan.push_back('{1'b0, ins, fa, da, az, e});
    endtask

    task automatic add_reset();
        ill_m = 1'b0;
        to_m  = 1'b0;
        plan.push_back('{1'b1, $urandom, 1'b0, 1'b1, rb(),
                         mk(3'd0, I, O, O, 4'd0, O, O, O, O, O, 2'd0)});
    endtask

    task automatic halt_tail();
        repeat ($urandom_range(2, 5))
            push($urandom, rb(), rb(), rb(), mk(3'd5, O, O, O, 4'd0, O, O, O, O, O, 2'd0));
        add_reset();
    endtask

    // Expand one instruction; fw/mw are ack delays (>15 means never), abort>=0 resets mid-MEM
    task automatic gen_instr(input logic [31:0] ins, input int fw, mw, input logic az,
                             input int abort);
        int         cls, nw;
        logic [3:0] alu;
        logic       tk, imm;
        dec(ins, cls, alu);
        nw = (fw > 15) ? 16 : fw;
        for (int k = 0; k < nw; k++)
            push($urandom, O, rb(), rb(), mk(3'd0, I, O, O, 4'd0, O, O, O, O, O, 2'd0));
        if (fw > 15) begin
            to_m = 1'b1;
            halt_tail();
            return;
        end
        push(ins, I, rb(), rb(), mk(3'd0, I, O, O, 4'd0, O, O, O, O, I, 2'd0));
        push($urandom, rb(), rb(), rb(),
             mk(3'd1, O, O, O, 4'd0, O, O, O, O, logic'(cls == 5), (cls == 5) ? 2'd2 : 2'd0));
        if (cls == 6) begin
            ill_m = 1'b1;
            halt_tail();
            return;
        end
        if (cls == 5) return;
        imm = (cls >= 1) && (cls <= 3);
        if (cls == 4) begin
            tk = ~az;
            push($urandom, rb(), rb(), az,
                 mk(3'd2, O, O, O, alu, O, O, O, O, tk, tk ? 2'd1 : 2'd0));
            return;
        end
        push($urandom, rb(), rb(), rb(), mk(3'd2, O, O, O, alu, imm, O, O, O, O, 2'd0));
        if (cls == 2 || cls == 3) begin
            nw = (abort >= 0) ? abort : ((mw > 15) ? 16 : mw);
            for (int k = 0; k < nw; k++)
                push($urandom, rb(), O, rb(),
                     mk(3'd3, O, I, logic'(cls == 3), 4'd0, O, O, O, O, O, 2'd0));
            if (abort >= 0) begin
                add_reset();
                return;
            end
            if (mw > 15) begin
                to_m = 1'b1;
                halt_tail();
                return;
            end
            push($urandom, rb(), I, rb(),
                 mk(3'd3, O, I, logic'(cls == 3), 4'd0, O, O, O, O, O, 2'd0));
            if (cls == 3) return;
        end
        push($urandom, rb(), rb(), rb(),
             mk(3'd4, O, O, O, 4'd0, O, I, logic'(cls == 0), logic'(cls == 2), O, 2'd0));
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r < 28) return r % 3;
        if (r < 36) return $urandom_range(3, 14);
        if (r < 38) return 15;
        return 16;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op, fn;
        w = $urandom;
        case ($urandom_range(0, 14))
            0, 1, 2, 3: op = 6'h00;
            4:  op = 6'h08;
            5:  op = 6'h23;
            6:  op = 6'h2B;
            7:  op = 6'h04;
            8:  op = 6'h05;
            9:  op = 6'h07;
            10: op = 6'h01;
            11: op = 6'h06;
            12: op = 6'h09;
            13: op = 6'h02;
            default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 7))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h00;
            5: fn = 6'h02;
            6: fn = 6'h2A;
            default: fn = 6'($urandom);
        endcase
        return {op, w[25:6], fn};
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Single compare process: DUT outputs vs the expanded trace, mid-cycle
    always @(negedge clk) begin
        logic [18:0] act;
        if (cur_valid) begin
            act = {state, fetch_req, dmem_req, dmem_we, alu_control, alu_src_imm, reg_write,
                   reg_dst_rd, mem_to_reg, pc_write, pc_src, illegal, timeout};
            olog.push_back(act);
            n_vec++;
            if (act !== cur.exp) begin
                n_err++;
                $display("FAIL cycle %0d outputs: got %h expected %h (state %0d)",
                         olog.size() - 1, act, cur.exp, state);
            end
        end
    end

    initial begin
        int a_add, a_lw, a_bt, a_bn, a_ill, a_to, a_sw;
        int e_add[5], e_lw[9];
        rst_n = 1'b0; instr = 32'd0; fetch_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;

        add_reset();
        a_add = plan.size(); gen_instr(32'h012A4020, 0, 0, 1'b0, -1);
        a_lw  = plan.size(); gen_instr(32'h8D280004, 0, 3, 1'b0, -1);
        a_bt  = plan.size(); gen_instr(32'h11090003, 0, 0, 1'b0, -1);
        a_bn  = plan.size(); gen_instr(32'h11090003, 0, 0, 1'b1, -1);
        a_ill = plan.size(); gen_instr(32'hFC000000, 0, 0, 1'b0, -1);
        a_to  = plan.size(); gen_instr(32'h012A4020, 16, 0, 1'b0, -1);
        a_sw  = plan.size(); gen_instr(32'hAD280004, 0, 0, 1'b0, 2);
        gen_instr(32'h012A4020, 1, 0, 1'b0, -1);
        gen_instr(32'h8D280004, 15, 15, 1'b0, -1);
        gen_instr(32'hAD280004, 2, 16, 1'b0, -1);
        for (int t = 0; t < 400; t++) begin
            if (t % 40 == 7)
                gen_instr(32'hAD280000 | 32'($urandom_range(0, 255)), pick_wait() % 15, 0,
                          1'b0, $urandom_range(0, 4));
            else
                gen_instr(rand_instr(), pick_wait(), pick_wait(), rb(), -1);
        end

        repeat (2) @(posedge clk);
        for (int k = 0; k < plan.size(); k++) begin
            @(posedge clk);
            #1;
            rst_n     = ~plan[k].rst;
            instr     = plan[k].ins;
            fetch_ack = plan[k].fa;
            dmem_ack  = plan[k].da;
            alu_zero  = plan[k].az;
            cur       = plan[k];
            cur_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;

        if (olog.size() != plan.size()) begin
            lit("trace length", olog.size(), plan.size());
        end else begin
            e_add = '{0, 1, 2, 4, 0};
            e_lw  = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
            lit("reset state", int'(olog[0][18:16]), 0);
            lit("reset fetch_req", int'(olog[0][15]), 1);
            for (int k = 0; k < 5; k++) lit("add state seq", int'(olog[a_add + k][18:16]), e_add[k]);
            lit("add exec alu", int'(olog[a_add + 2][12:9]), 0);
            lit("add wb rw/rd", int'(olog[a_add + 3][7:6]), 3);
            for (int k = 0; k < 9; k++) lit("lw state seq", int'(olog[a_lw + k][18:16]), e_lw[k]);
            lit("lw mem req/we", int'(olog[a_lw + 4][14:13]), 2);
            lit("lw wb mem_to_reg", int'(olog[a_lw + 7][5]), 1);
            lit("beq alu", int'(olog[a_bt + 2][12:9]), 7);
            lit("beq taken pcw/src", int'(olog[a_bt + 2][4:2]), 5);
            lit("beq not taken pcw", int'(olog[a_bn + 2][4]), 0);
            lit("beq return fetch", int'(olog[a_bn + 3][18:16]), 0);
            lit("illegal decode", int'(olog[a_ill + 1][18:16]), 1);
            lit("illegal halt", int'(olog[a_ill + 2][18:16]), 5);
            lit("illegal flag", int'(olog[a_ill + 3][1]), 1);
            lit("timeout last fetch", int'(olog[a_to + 15][18:16]), 0);
            lit("timeout halt", int'(olog[a_to + 16][18:16]), 5);
            lit("timeout flag", int'(olog[a_to + 16][0]), 1);
            lit("sw mid-mem", int'(olog[a_sw + 4][18:16]), 3);
            lit("sw reset dmem_req", int'(olog[a_sw + 5][14]), 0);
            lit("sw reset state", int'(olog[a_sw + 5][18:16]), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
